// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the divide sequencer slice.
//   op_t     : request opcodes carried on req_op.
//   state_t  : sequencer FSM states, also exported on the debug state port.
//   INT_MIN  : 32-bit most-negative value. Dividing it by -1 overflows, so the
//              sequencer answers that pair itself.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_MTHI = 2'b01,
    OP_MTLO = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    COMMIT = 3'd3,
    EXC    = 3'd4,
    ABORT  = 3'd5
  } state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/div_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_sequencer_if
// Request channel from the control unit into the divide sequencer.
//   req_valid : request present
//   req_op    : op_t opcode
//   req_a     : dividend, or data for MTHI/MTLO
//   req_b     : divisor
//   req_ready : sequencer can accept (only when idle)
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. While req_valid is high and the request has not
// transferred, the requester keeps req_op/req_a/req_b unchanged; the
// sequencer never queues, it simply holds req_ready low while busy.
// -----------------------------------------------------------------------------
interface div_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             req_valid;
  op_t              req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_ready;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready
  );

endinterface

// File: rtl/div_watchdog.sv
// -----------------------------------------------------------------------------
// div_watchdog
// Counts cycles spent waiting on the divider and flags when the limit is hit.
//   clk, reset : clock, synchronous active-low reset
//   clear      : zero the counter (sequencer in LAUNCH)
//   run        : count this cycle (sequencer in WAIT)
//   expired    : high during the LIMIT-th consecutive run cycle
// -----------------------------------------------------------------------------
module div_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of run cycles already completed, so the LIMIT-th
  // run cycle sees LIMIT-1 and is the one that raises expired.
  assign expired = run && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Drives the iterative signed divider for the multicycle control unit and
// owns the architected HI/LO registers.
//   clk, reset          : clock, synchronous active-low reset
//   req (slave)         : DIV/MTHI/MTLO request channel, see div_sequencer_if
//   div_ctrl            : one-cycle start pulse to the divider
//   div_in_a, div_in_b  : latched operands, stable from LAUNCH through WAIT
//   div_hi, div_lo      : divider remainder / quotient
//   div_end             : divider done (divider clears it on div_ctrl)
//   hi, lo              : architected HI/LO
//   busy                : high whenever not idle, stalls MFHI/MFLO
//   done                : one-cycle pulse when a request retires
//   div_zero            : one-cycle pulse, DIV with zero divisor
//   div_tmo             : one-cycle pulse, divider wait abandoned
//   dbg_state           : current FSM state
// Build option: define DIV_SEQ_TIMEOUT_EN to bound the divider wait to
// TIMEOUT_CYCLES cycles; without it the wait lasts until div_end and
// div_tmo is tied low.
// -----------------------------------------------------------------------------
module div_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  div_sequencer_if.slave   req,
  output logic             div_ctrl,
  output logic [WIDTH-1:0] div_in_a,
  output logic [WIDTH-1:0] div_in_b,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic             div_end,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             div_tmo,
  output state_t           dbg_state
);

  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic             hi_we, lo_we, opnd_we;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             tmo_expired;

  // ---------------------------------------------------------------------------
  // State and architected registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      hi       <= '0;
      lo       <= '0;
      div_in_a <= '0;
      div_in_b <= '0;
    end else begin
      state_q <= state_d;
      if (hi_we)   hi       <= hi_d;
      if (lo_we)   lo       <= lo_d;
      if (opnd_we) begin
        div_in_a <= req.req_a;
        div_in_b <= req.req_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and register write enables. HI/LO are written on the edge that
  // enters COMMIT, so the new values and the done pulse appear together.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_d    = div_hi;
    lo_d    = div_lo;
    opnd_we = 1'b0;

    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          case (req.req_op)
            OP_DIV: begin
              if (req.req_b == '0) begin
                state_d = EXC;
              end else if (req.req_a == MIN_W && req.req_b == '1) begin
                // Quotient overflows the divider; the architected answer is
                // INT_MIN with a zero remainder.
                state_d = COMMIT;
                hi_we   = 1'b1;
                lo_we   = 1'b1;
                hi_d    = '0;
                lo_d    = MIN_W;
              end else begin
                state_d = LAUNCH;
                opnd_we = 1'b1;
              end
            end
            OP_MTHI: begin
              state_d = COMMIT;
              hi_we   = 1'b1;
              hi_d    = req.req_a;
            end
            OP_MTLO: begin
              state_d = COMMIT;
              lo_we   = 1'b1;
              lo_d    = req.req_a;
            end
            default: state_d = COMMIT;
          endcase
        end
      end
      // div_end may still be high from the previous divide during LAUNCH;
      // it is only trusted once the divider has seen div_ctrl.
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (div_end) begin
          state_d = COMMIT;
          hi_we   = 1'b1;
          lo_we   = 1'b1;
        end else if (tmo_expired) begin
          state_d = ABORT;
        end
      end
      COMMIT, EXC, ABORT: state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  assign req.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign div_ctrl      = (state_q == LAUNCH);
  assign done          = (state_q == COMMIT) || (state_q == EXC) || (state_q == ABORT);
  assign div_zero      = (state_q == EXC);
  assign dbg_state     = state_q;

`ifdef DIV_SEQ_TIMEOUT_EN
  logic wd_clear, wd_run;
  assign wd_clear = (state_q == LAUNCH);
  assign wd_run   = (state_q == WAIT);

  div_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(tmo_expired)
  );

  assign div_tmo = (state_q == ABORT);
`else
  assign tmo_expired = 1'b0;
  assign div_tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int TMO = 8;
`ifdef DIV_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  div_sequencer_if #(.WIDTH(W)) req_if ();

  logic         div_ctrl;
  logic [W-1:0] div_in_a, div_in_b, div_hi, div_lo, hi, lo;
  logic         div_end, busy, done, div_zero, div_tmo;
  state_t       dbg_state;

  div_sequencer #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req_if),
    .div_ctrl (div_ctrl),
    .div_in_a (div_in_a),
    .div_in_b (div_in_b),
    .div_hi   (div_hi),
    .div_lo   (div_lo),
    .div_end  (div_end),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .div_tmo  (div_tmo),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    int           cyc;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         tmo;
  } retire_t;

  typedef struct {
    int           cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold_end;
  } launch_t;

  retire_t      exp_q[$];
  launch_t      launch_q[$];
  int           lat_q[$];
  logic [W-1:0] mdl_hi = '0, mdl_lo = '0;
  logic [W-1:0] cur_hi = '0, cur_lo = '0;
  int           busy_lo = 1, busy_hi = 0;
  int           hold_end = -1;
  logic [W-1:0] hold_a = '0, hold_b = '0;

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_event(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural divider: answers N cycles after it sees the start pulse
  // ---------------------------------------------------------------------------
  initial begin
    logic         pend;
    int           dcnt;
    logic [W-1:0] da, db;
    pend = 1'b0; dcnt = 0; da = '0; db = '0;
    div_end = 1'b0; div_hi = '0; div_lo = '0;
    forever begin
      @(negedge clk);
      if (div_ctrl) begin
        div_end = 1'b0;
        pend    = 1'b1;
        dcnt    = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        da      = div_in_a;
        db      = div_in_b;
      end else if (pend) begin
        if (dcnt == 0) begin
          div_end = 1'b1;
          div_hi  = (db == '0) ? '1 : W'($signed(da) % $signed(db));
          div_lo  = (db == '0) ? '1 : W'($signed(da) / $signed(db));
          pend    = 1'b0;
        end else begin
          dcnt--;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every out-of-reset cycle
  // ---------------------------------------------------------------------------
  initial begin
    retire_t e;
    launch_t l;
    logic    exp_busy;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        check("busy", W'(busy), W'(exp_busy));
        check("req_ready", W'(req_if.req_ready), W'(!exp_busy));

        if (done) begin
          if (exp_q.size() == 0) begin
            fail_event("done_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", W'(cyc), W'(e.cyc));
            check("div_zero", W'(div_zero), W'(e.zero));
            check("div_tmo", W'(div_tmo), W'(e.tmo));
            cur_hi = e.hi;
            cur_lo = e.lo;
          end
        end else begin
          check("pulse_idle", W'({div_zero, div_tmo}), '0);
          if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            fail_event("done_missing", cyc, exp_q[0].cyc);
            e = exp_q.pop_front();
            cur_hi = e.hi;
            cur_lo = e.lo;
          end
        end
        check("hi", hi, cur_hi);
        check("lo", lo, cur_lo);

        if (div_ctrl) begin
          if (launch_q.size() == 0) begin
            fail_event("div_ctrl_unexpected", 1, 0);
          end else begin
            l = launch_q.pop_front();
            check("launch_cycle", W'(cyc), W'(l.cyc));
            hold_a   = l.a;
            hold_b   = l.b;
            hold_end = l.hold_end;
          end
        end else if (launch_q.size() > 0 && launch_q[0].cyc < cyc) begin
          fail_event("div_ctrl_missing", cyc, launch_q[0].cyc);
          void'(launch_q.pop_front());
        end
        if (cyc <= hold_end) begin
          check("div_in_a", div_in_a, hold_a);
          check("div_in_b", div_in_b, hold_b);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: issue one request, record what the model says must follow
  // ---------------------------------------------------------------------------
  task automatic do_req(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int n, output int waited);
    int      t, lat;
    retire_t e;
    launch_t lc;
    waited = 0;
    @(negedge clk);
    req_if.req_valid = 1'b1;
    req_if.req_op    = op;
    req_if.req_a     = a;
    req_if.req_b     = b;
    while (!req_if.req_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!req_if.req_ready) begin
      fail_event("accept_timeout", waited, 2000);
      req_if.req_valid = 1'b0;
      return;
    end
    t      = cyc + 1;
    lat    = 1;
    e.hi   = mdl_hi;
    e.lo   = mdl_lo;
    e.zero = 1'b0;
    e.tmo  = 1'b0;
    case (op)
      OP_MTHI: e.hi = a;
      OP_MTLO: e.lo = a;
      OP_DIV: begin
        if (b == '0) begin
          e.zero = 1'b1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
          e.hi = '0;
          e.lo = INT_MIN;
        end else begin
          if (TMO_EN && n >= TMO) begin
            e.tmo = 1'b1;
            lat   = 2 + TMO;
          end else begin
            e.hi = W'($signed(a) % $signed(b));
            e.lo = W'($signed(a) / $signed(b));
            lat  = 3 + n;
          end
          lc.cyc      = t;
          lc.a        = a;
          lc.b        = b;
          lc.hold_end = t + lat - 2;
          launch_q.push_back(lc);
          lat_q.push_back(n);
        end
      end
      default: ;
    endcase
    e.cyc = t + lat - 1;
    exp_q.push_back(e);
    mdl_hi  = e.hi;
    mdl_lo  = e.lo;
    busy_lo = t;
    busy_hi = t + lat - 1;
    @(posedge clk);
    #1;
    req_if.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() > 0 || cyc <= busy_hi) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) fail_event("idle_timeout", k, 3000);
  endtask

  task automatic model_reset();
    exp_q.delete();
    launch_q.delete();
    lat_q.delete();
    mdl_hi   = '0;
    mdl_lo   = '0;
    cur_hi   = '0;
    cur_lo   = '0;
    busy_lo  = 1;
    busy_hi  = 0;
    hold_end = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int           w, w2, sel, n;
    op_t          op;
    logic [W-1:0] a, b;

    req_if.req_valid = 1'b0;
    req_if.req_op    = OP_DIV;
    req_if.req_a     = '0;
    req_if.req_b     = '0;
    reset            = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_ready", W'(req_if.req_ready), 1);
    check("rst_pulses", W'({done, div_ctrl, div_zero, div_tmo}), '0);
    check("rst_div_in_a", div_in_a, '0);
    check("rst_div_in_b", div_in_b, '0);
    reset = 1'b1;

    // Plain divides with hand-computed results
    do_req(OP_DIV, 32'd7, 32'd2, 5, w);
    wait_idle();
    check("t1_hi", hi, 32'd1);
    check("t1_lo", lo, 32'd3);

    do_req(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, w);
    wait_idle();
    check("neg_hi", hi, 32'hFFFF_FFFF);
    check("neg_lo", lo, 32'hFFFF_FFFD);

    // Zero divisor keeps HI/LO
    do_req(OP_DIV, 32'd5, 32'd0, 0, w);
    wait_idle();
    check("t2_hi", hi, 32'hFFFF_FFFF);
    check("t2_lo", lo, 32'hFFFF_FFFD);

    // Overflow pair
    do_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, w);
    wait_idle();
    check("t3_hi", hi, 32'h0);
    check("t3_lo", lo, 32'h8000_0000);

    // MTHI then DIV back to back: DIV held off one cycle
    do_req(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0, w);
    do_req(OP_DIV, 32'd100, 32'd7, 2, w2);
    check("t4_holdoff", W'(w2), 32'd1);
    wait_idle();
    check("t4_hi", hi, 32'd2);
    check("t4_lo", lo, 32'd14);

    do_req(OP_MTLO, 32'h0000_5678, 32'd0, 0, w);
    do_req(OP_RSVD, 32'h1111_1111, 32'd9, 0, w);
    do_req(OP_MTHI, 32'h0000_1234, 32'd0, 0, w);
    wait_idle();
    check("mt_hi", hi, 32'h0000_1234);
    check("mt_lo", lo, 32'h0000_5678);

    if (TMO_EN) begin
      do_req(OP_DIV, 32'd1000, 32'd3, 100000, w);
      wait_idle();
      check("t6_hi", hi, 32'h0000_1234);
      check("t6_lo", lo, 32'h0000_5678);
      do_req(OP_DIV, 32'd1000, 32'd3, TMO - 1, w);
      wait_idle();
    end else begin
      do_req(OP_DIV, 32'd1000, 32'd3, 40, w);
      wait_idle();
    end
    check("long_hi", hi, 32'd1);
    check("long_lo", lo, 32'd333);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 15);
      op  = op_t'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) op = OP_DIV;
      a = $urandom();
      b = $urandom();
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = INT_MIN; b = '1; end
      else if (sel < 6) b = W'($urandom_range(1, 9));
      else if (sel < 9) b = -W'($urandom_range(1, 9));
      n = $urandom_range(0, 11);
      do_req(op, a, b, n, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    // Reset in the middle of a wait; the divider answers afterwards
    do_req(OP_DIV, 32'd100, 32'd7, 6, w);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    check("t5_hi", hi, '0);
    check("t5_lo", lo, '0);
    check("t5_busy", W'(busy), '0);
    check("t5_div_in_a", div_in_a, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_late_hi", hi, '0);
    check("t5_late_busy", W'(busy), '0);

    do_req(OP_DIV, 32'd50, 32'd7, 1, w);
    wait_idle();
    check("post_rst_hi", hi, 32'd1);
    check("post_rst_lo", lo, 32'd7);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
